// File: rtl/ps2_key_tracker_pkg.sv
// Scan codes, key bit positions and decoder state encoding for the PS/2 key tracker.
// Also holds the code-to-key mapping helpers shared by the decoder.
package ps2_key_pkg;

  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_ESC     = 8'h76;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_BAT_ERR = 8'hFC;

  localparam int KEY_A     = 0;
  localparam int KEY_D     = 1;
  localparam int KEY_ENTER = 2;
  localparam int KEY_ESC   = 3;
  localparam int KEY_SPACE = 4;
  localparam int NUM_KEYS  = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  // One-hot key mask for a plain (non-extended) scan code; zero when unmapped.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = {NUM_KEYS{1'b0}};
    case (code)
      SC_A:     m[KEY_A]     = 1'b1;
      SC_D:     m[KEY_D]     = 1'b1;
      SC_ENTER: m[KEY_ENTER] = 1'b1;
      SC_ESC:   m[KEY_ESC]   = 1'b1;
      SC_SPACE: m[KEY_SPACE] = 1'b1;
      default:  m = {NUM_KEYS{1'b0}};
    endcase
    return m;
  endfunction

  // Arrow keys behind an E0 prefix alias the A/D movement keys.
  function automatic logic [NUM_KEYS-1:0] ext_mask(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = {NUM_KEYS{1'b0}};
    case (code)
      SC_LEFT:  m[KEY_A] = 1'b1;
      SC_RIGHT: m[KEY_D] = 1'b1;
      default:  m = {NUM_KEYS{1'b0}};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte-stream input and key-state output bundle between the PS/2 receiver side
// and the key tracker.
interface ps2_key_tracker_if;
  import ps2_key_pkg::*;

  logic [7:0]          received_data;
  logic                received_data_en;
  logic                clear;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic                move_left;
  logic                move_right;
  logic [1:0]          decode_state;

  modport master (
    output received_data, received_data_en, clear,
    input  key_held, key_press, move_left, move_right, decode_state
  );

  modport slave (
    input  received_data, received_data_en, clear,
    output key_held, key_press, move_left, move_right, decode_state
  );

endinterface

// File: rtl/ps2_key_tracker_autorepeat.sv
// Delayed auto-shift / auto-repeat strobe generator: fires on press, again after
// DAS_CYCLES, then every ARR_CYCLES while the key stays held.
module key_autorepeat #(
  parameter int DAS_CYCLES = 8500000,
  parameter int ARR_CYCLES = 2500000,
  parameter int CNT_W      = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic srst,
  input  logic press,
  input  logic held,
  output logic strobe
);

  logic [CNT_W-1:0] cnt_r;
  logic             active_r;
  logic             strobe_r;

  // A fresh press restarts DAS even if a repeat was already running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      active_r <= 1'b0;
      strobe_r <= 1'b0;
    end else if (srst) begin
      cnt_r    <= {CNT_W{1'b0}};
      active_r <= 1'b0;
      strobe_r <= 1'b0;
    end else if (press) begin
      cnt_r    <= CNT_W'(DAS_CYCLES - 1);
      active_r <= 1'b1;
      strobe_r <= 1'b1;
    end else if (active_r && held) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        cnt_r    <= CNT_W'(ARR_CYCLES - 1);
        strobe_r <= 1'b1;
      end else begin
        cnt_r    <= cnt_r - CNT_W'(1'b1);
        strobe_r <= 1'b0;
      end
    end else begin
      cnt_r    <= {CNT_W{1'b0}};
      active_r <= 1'b0;
      strobe_r <= 1'b0;
    end
  end

  assign strobe = strobe_r;

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes the PS/2 make/break/extended byte stream into held-key state, press
// pulses and auto-repeating left/right move strobes.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int DAS_CYCLES     = 8500000,
  parameter int ARR_CYCLES     = 2500000,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  ps2_key_tracker_if.slave   bus
);

  localparam int MAX_AB  = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int MAX_CYC = (MAX_AB > PREFIX_TIMEOUT) ? MAX_AB : PREFIX_TIMEOUT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [1:0]          state_r, state_next_s;
  logic [NUM_KEYS-1:0] held_r, held_next_s;
  logic [NUM_KEYS-1:0] press_r, press_next_s;
  logic [CNT_W-1:0]    to_cnt_r;
  logic                timeout_s;
  dir_t                dir_r, dir_next_s;
  logic                ar_press_s, ar_held_s, ar_strobe_s;

  assign timeout_s = (state_r != ST_IDLE) && (to_cnt_r == CNT_W'(PREFIX_TIMEOUT - 1));

  // Byte decoder: clear wins over a coincident strobe and drops that byte.
  always_comb begin
    held_next_s  = held_r;
    state_next_s = state_r;
    if (bus.clear) begin
      held_next_s  = {NUM_KEYS{1'b0}};
      state_next_s = ST_IDLE;
    end else if (bus.received_data_en) begin
      case (state_r)
        ST_IDLE: begin
          case (bus.received_data)
            SC_BREAK:              state_next_s = ST_BRK;
            SC_EXT:                state_next_s = ST_EXT;
            SC_BAT_OK, SC_BAT_ERR: held_next_s  = {NUM_KEYS{1'b0}};
            default:               held_next_s  = held_r | key_mask(bus.received_data);
          endcase
        end
        ST_BRK: begin
          held_next_s  = held_r & ~key_mask(bus.received_data);
          state_next_s = ST_IDLE;
        end
        ST_EXT: begin
          if (bus.received_data == SC_BREAK) begin
            state_next_s = ST_EXT_BRK;
          end else begin
            held_next_s  = held_r | ext_mask(bus.received_data);
            state_next_s = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          held_next_s  = held_r & ~ext_mask(bus.received_data);
          state_next_s = ST_IDLE;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else if (timeout_s) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_r;
    end
  end

  assign press_next_s = held_next_s & ~held_r;

  // Last press wins; releasing the active key stops repeat even if the other is held.
  always_comb begin
    dir_next_s = dir_r;
    if (bus.clear) begin
      dir_next_s = DIR_NONE;
    end else if (press_next_s[KEY_A]) begin
      dir_next_s = DIR_LEFT;
    end else if (press_next_s[KEY_D]) begin
      dir_next_s = DIR_RIGHT;
    end else if ((dir_r == DIR_LEFT) && !held_next_s[KEY_A]) begin
      dir_next_s = DIR_NONE;
    end else if ((dir_r == DIR_RIGHT) && !held_next_s[KEY_D]) begin
      dir_next_s = DIR_NONE;
    end else begin
      dir_next_s = dir_r;
    end
  end

  // Held level of whichever direction key owns the repeat engine next cycle.
  always_comb begin
    ar_held_s = 1'b0;
    case (dir_next_s)
      DIR_LEFT:  ar_held_s = held_next_s[KEY_A];
      DIR_RIGHT: ar_held_s = held_next_s[KEY_D];
      default:   ar_held_s = 1'b0;
    endcase
  end

  assign ar_press_s = press_next_s[KEY_A] | press_next_s[KEY_D];

  // Decoder state, key state and repeat direction registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      held_r  <= {NUM_KEYS{1'b0}};
      press_r <= {NUM_KEYS{1'b0}};
      dir_r   <= DIR_NONE;
    end else begin
      state_r <= state_next_s;
      held_r  <= held_next_s;
      press_r <= press_next_s;
      dir_r   <= dir_next_s;
    end
  end

  // Prefix watchdog, kept separate because a prefix can arrive while a key repeats.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.clear || bus.received_data_en || (state_r == ST_IDLE) || timeout_s) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + CNT_W'(1'b1);
    end
  end

  key_autorepeat #(
    .DAS_CYCLES (DAS_CYCLES),
    .ARR_CYCLES (ARR_CYCLES),
    .CNT_W      (CNT_W)
  ) u_autorepeat (
    .clk    (CLOCK_50),
    .rst_n  (reset),
    .srst   (bus.clear),
    .press  (ar_press_s),
    .held   (ar_held_s),
    .strobe (ar_strobe_s)
  );

  assign bus.key_held     = held_r;
  assign bus.key_press    = press_r;
  assign bus.decode_state = state_r;
  assign bus.move_left    = ar_strobe_s & (dir_r == DIR_LEFT);
  assign bus.move_right   = ar_strobe_s & (dir_r == DIR_RIGHT);

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed vector table, multi-cycle corner sequences
// and random byte streams against a schedule-based reference model.
module tb_ps2_key_tracker;
  import ps2_key_pkg::*;

  localparam int DAS = 20;
  localparam int ARR = 5;
  localparam int TO  = 30;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;

  ps2_key_tracker_if bus();

  ps2_key_tracker #(
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR),
    .PREFIX_TIMEOUT (TO)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: key set, pending prefix flags, quiet-time and absolute fire schedule.
  bit [4:0] m_held, m_press;
  bit       m_ml, m_mr, m_ext, m_brk;
  int       m_quiet, m_dir, m_cyc, m_next_fire;

  function automatic bit [4:0] kmask(input bit [7:0] d);
    if (d == 8'h1C) return 5'b00001;
    if (d == 8'h23) return 5'b00010;
    if (d == 8'h5A) return 5'b00100;
    if (d == 8'h76) return 5'b01000;
    if (d == 8'h29) return 5'b10000;
    return 5'b00000;
  endfunction

  task automatic m_reset();
    m_held = 5'b0; m_press = 5'b0; m_ml = 1'b0; m_mr = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_quiet = 0; m_dir = 0; m_next_fire = 0;
  endtask

  task automatic m_step(input bit clr, input bit en, input bit [7:0] d);
    bit [4:0] prev;
    prev = m_held;
    m_cyc++;
    m_ml = 1'b0; m_mr = 1'b0;
    if (clr) begin
      m_reset();
      return;
    end
    if (en) begin
      m_quiet = 0;
      if (!m_ext && !m_brk) begin
        if (d == 8'hF0) m_brk = 1'b1;
        else if (d == 8'hE0) m_ext = 1'b1;
        else if (d == 8'hAA || d == 8'hFC) m_held = 5'b0;
        else m_held = m_held | kmask(d);
      end else if (m_brk && !m_ext) begin
        m_held = m_held & ~kmask(d);
        m_brk = 1'b0;
      end else if (!m_brk) begin
        if (d == 8'hF0) m_brk = 1'b1;
        else begin
          if (d == 8'h6B) m_held[0] = 1'b1;
          if (d == 8'h74) m_held[1] = 1'b1;
          m_ext = 1'b0;
        end
      end else begin
        if (d == 8'h6B) m_held[0] = 1'b0;
        if (d == 8'h74) m_held[1] = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else if (m_ext || m_brk) begin
      m_quiet++;
      if (m_quiet >= TO) begin m_ext = 1'b0; m_brk = 1'b0; m_quiet = 0; end
    end
    m_press = m_held & ~prev;
    if (m_press[0]) begin
      m_dir = 1; m_next_fire = m_cyc + DAS; m_ml = 1'b1;
    end else if (m_press[1]) begin
      m_dir = 2; m_next_fire = m_cyc + DAS; m_mr = 1'b1;
    end else if ((m_dir == 1 && !m_held[0]) || (m_dir == 2 && !m_held[1])) begin
      m_dir = 0;
    end else if (m_dir != 0 && m_cyc == m_next_fire) begin
      if (m_dir == 1) m_ml = 1'b1; else m_mr = 1'b1;
      m_next_fire = m_cyc + ARR;
    end
  endtask

  task automatic cmp(input string name, input logic [4:0] eh, input logic [4:0] ep,
                     input logic eml, input logic emr, input logic [1:0] est);
    n_vec++;
    if (bus.key_held !== eh || bus.key_press !== ep || bus.move_left !== eml ||
        bus.move_right !== emr || bus.decode_state !== est) begin
      n_err++;
      $display("FAIL %s t=%0t got held=%b press=%b ml=%b mr=%b st=%0d want held=%b press=%b ml=%b mr=%b st=%0d",
               name, $time, bus.key_held, bus.key_press, bus.move_left, bus.move_right,
               bus.decode_state, eh, ep, eml, emr, est);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick(input bit clr, input bit en, input bit [7:0] d);
    bus.clear = clr; bus.received_data_en = en; bus.received_data = d;
    @(posedge CLOCK_50); #1;
    m_step(clr, en, d);
    bus.clear = 1'b0; bus.received_data_en = 1'b0;
  endtask

  task automatic tick_chk(input string name, input bit clr, input bit en, input bit [7:0] d);
    tick(clr, en, d);
    cmp(name, m_held, m_press, m_ml, m_mr, {m_ext, m_brk});
  endtask

  typedef struct {
    bit clr; bit en; bit [7:0] d;
    bit [4:0] held; bit [4:0] press; bit ml; bit mr; bit [1:0] st;
  } vec_t;

  vec_t tbl[19];
  bit [7:0] pool[12];

  initial begin
    int ml_cnt, mr_cnt, first_mr;
    int fires[$];
    bus.clear = 1'b0; bus.received_data_en = 1'b0; bus.received_data = 8'h00;
    m_reset(); m_cyc = 0;

    tbl[0]  = '{0, 1, 8'h1C, 5'b00001, 5'b00001, 1, 0, 2'd0};
    tbl[1]  = '{0, 0, 8'h00, 5'b00001, 5'b00000, 0, 0, 2'd0};
    tbl[2]  = '{0, 1, 8'h1C, 5'b00001, 5'b00000, 0, 0, 2'd0};
    tbl[3]  = '{0, 1, 8'hF0, 5'b00001, 5'b00000, 0, 0, 2'd1};
    tbl[4]  = '{0, 1, 8'h1C, 5'b00000, 5'b00000, 0, 0, 2'd0};
    tbl[5]  = '{0, 1, 8'hE0, 5'b00000, 5'b00000, 0, 0, 2'd2};
    tbl[6]  = '{0, 1, 8'h6B, 5'b00001, 5'b00001, 1, 0, 2'd0};
    tbl[7]  = '{0, 1, 8'hE0, 5'b00001, 5'b00000, 0, 0, 2'd2};
    tbl[8]  = '{0, 1, 8'hF0, 5'b00001, 5'b00000, 0, 0, 2'd3};
    tbl[9]  = '{0, 1, 8'h6B, 5'b00000, 5'b00000, 0, 0, 2'd0};
    tbl[10] = '{0, 1, 8'h6B, 5'b00000, 5'b00000, 0, 0, 2'd0};
    tbl[11] = '{0, 1, 8'h29, 5'b10000, 5'b10000, 0, 0, 2'd0};
    tbl[12] = '{0, 1, 8'h5A, 5'b10100, 5'b00100, 0, 0, 2'd0};
    tbl[13] = '{0, 1, 8'hAA, 5'b00000, 5'b00000, 0, 0, 2'd0};
    tbl[14] = '{0, 1, 8'h76, 5'b01000, 5'b01000, 0, 0, 2'd0};
    tbl[15] = '{1, 1, 8'h23, 5'b00000, 5'b00000, 0, 0, 2'd0};
    tbl[16] = '{0, 1, 8'h23, 5'b00010, 5'b00010, 0, 1, 2'd0};
    tbl[17] = '{0, 1, 8'hF0, 5'b00010, 5'b00000, 0, 0, 2'd1};
    tbl[18] = '{0, 1, 8'h23, 5'b00000, 5'b00000, 0, 0, 2'd0};

    pool = '{8'h1C, 8'h23, 8'h5A, 8'h76, 8'h29, 8'hF0, 8'hE0, 8'h6B,
             8'h74, 8'hAA, 8'hFC, 8'h12};

    // Reset values
    repeat (2) @(posedge CLOCK_50);
    #1;
    cmp("reset", 5'b0, 5'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].clr, tbl[i].en, tbl[i].d);
      cmp($sformatf("table[%0d]", i), tbl[i].held, tbl[i].press, tbl[i].ml, tbl[i].mr, tbl[i].st);
    end

    // Hold A: pulses at 0, DAS, DAS+ARR, ... then silence after release
    tick_chk("das_clr", 1'b1, 1'b0, 8'h00);
    ml_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0)       tick_chk("das_hold", 1'b0, 1'b1, 8'h1C);
      else if (i == 38) tick_chk("das_hold", 1'b0, 1'b1, 8'hF0);
      else if (i == 39) tick_chk("das_hold", 1'b0, 1'b1, 8'h1C);
      else              tick_chk("das_hold", 1'b0, 1'b0, 8'h00);
      if (bus.move_left) fires.push_back(i);
    end
    expect_int("das_fire_count", fires.size(), 5);
    if (fires.size() == 5) begin
      expect_int("das_fire0", fires[0], 0);
      expect_int("das_fire1", fires[1], DAS);
      expect_int("das_fire2", fires[2], DAS + ARR);
      expect_int("das_fire3", fires[3], DAS + 2 * ARR);
      expect_int("das_fire4", fires[4], DAS + 3 * ARR);
    end
    for (int i = 0; i < 15; i++) begin
      tick_chk("das_after", 1'b0, 1'b0, 8'h00);
      if (bus.move_left) ml_cnt++;
    end
    expect_int("das_after_release", ml_cnt, 0);

    // A then D: D restarts DAS; after D release, A still held but no pulses
    tick_chk("dir_clr", 1'b1, 1'b0, 8'h00);
    tick_chk("dir_a", 1'b0, 1'b1, 8'h1C);
    for (int i = 1; i < 5; i++) tick_chk("dir_wait", 1'b0, 1'b0, 8'h00);
    tick_chk("dir_d", 1'b0, 1'b1, 8'h23);
    expect_int("dir_d_pulse", int'(bus.move_right), 1);
    ml_cnt = 0; first_mr = -1;
    for (int i = 6; i < 28; i++) begin
      tick_chk("dir_run", 1'b0, 1'b0, 8'h00);
      if (bus.move_left) ml_cnt++;
      if (bus.move_right && first_mr < 0) first_mr = i;
    end
    expect_int("dir_no_left", ml_cnt, 0);
    expect_int("dir_first_repeat", first_mr, 5 + DAS);
    tick_chk("dir_rel", 1'b0, 1'b1, 8'hF0);
    tick_chk("dir_rel", 1'b0, 1'b1, 8'h23);
    ml_cnt = 0; mr_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick_chk("dir_after", 1'b0, 1'b0, 8'h00);
      if (bus.move_left) ml_cnt++;
      if (bus.move_right) mr_cnt++;
    end
    expect_int("dir_after_moves", ml_cnt + mr_cnt, 0);
    expect_int("dir_a_still_held", int'(bus.key_held[0]), 1);

    // Prefix timeout then a make code
    tick_chk("to_clr", 1'b1, 1'b0, 8'h00);
    tick_chk("to_f0", 1'b0, 1'b1, 8'hF0);
    for (int i = 1; i <= TO; i++) begin
      tick_chk("to_wait", 1'b0, 1'b0, 8'h00);
      if (i == TO - 1) expect_int("to_before", int'(bus.decode_state), 1);
      if (i == TO)     expect_int("to_expired", int'(bus.decode_state), 0);
    end
    tick_chk("to_make", 1'b0, 1'b1, 8'h29);
    expect_int("to_space_held", int'(bus.key_held[4]), 1);

    // Asynchronous reset in the middle of an extended prefix
    tick_chk("ar_a", 1'b0, 1'b1, 8'h1C);
    tick_chk("ar_e0", 1'b0, 1'b1, 8'hE0);
    #2 reset = 1'b0;
    #1 cmp("async_reset", 5'b0, 5'b0, 1'b0, 1'b0, 2'd0);
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    m_reset();

    // Random byte streams with alternating busy/quiet phases
    for (int i = 0; i < 600; i++) begin
      bit en, clr;
      bit [7:0] d;
      if ((i / 60) % 2 == 0) en = ($urandom_range(0, 2) == 0);
      else                   en = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 63) == 0);
      d = pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) d = 8'($urandom);
      tick_chk("random", clr, en, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sequences the raw PS/2 byte stream (received_data / received_data_en from PS2_Controller) into game-level key state for the Tetris core.
- Decodes make codes, break (F0) prefixes and extended (E0) prefixes, and keeps a per-key held register for A, D, Enter, Esc and Space.
- Emits one-cycle press pulses and auto-repeating move_left/move_right strobes.
- Replaces last-byte-equals-code decoding, so releases and simultaneous keys are handled correctly.

Parameters:
- DAS_CYCLES, 8500000, cycles from initial move pulse to first auto-repeat (170 ms at 50 MHz).
- ARR_CYCLES, 2500000, cycles between subsequent auto-repeat pulses (50 ms).
- PREFIX_TIMEOUT, 50000, cycles a prefix state may wait for its next byte before abandoning it (1 ms).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- received_data  in  8  scan code byte from PS2_Controller.
- received_data_en  in  1  one-cycle strobe; received_data is valid this cycle.
- clear  in  1  synchronous; drops all held keys and repeat state.
- key_held  out  5  bit0 A, bit1 D, bit2 Enter, bit3 Esc, bit4 Space; 1 while held.
- key_press  out  5  same bit order; one-cycle pulse on the 0->1 transition of key_held.
- move_left  out  1  one-cycle strobe: A press plus auto-repeat.
- move_right  out  1  one-cycle strobe: D press plus auto-repeat.
- decode_state  out  2  current FSM state, for debug LEDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - key_held=0, key_press=0, move_left=0, move_right=0.
  - FSM=IDLE; repeat counter=0; active_dir=NONE.
- FSM states, encoded IDLE=0, BRK=1, EXT=2, EXT_BRK=3. Transitions occur only on received_data_en:
  - IDLE:
    - byte F0 -> BRK.
    - byte E0 -> EXT.
    - a mapped code sets its held bit.
    - byte AA (BAT pass) or FC (BAT fail) clears all held bits.
    - any other byte is ignored.
  - BRK: a mapped code clears its held bit. Any byte -> IDLE.
  - EXT:
    - byte F0 -> EXT_BRK.
    - 6B (left arrow) aliases A make; 74 (right arrow) aliases D make.
    - other bytes are ignored.
    - any byte other than F0 -> IDLE.
  - EXT_BRK: 6B clears A, 74 clears D. Any byte -> IDLE.
- Code map: 1C=A, 23=D, 5A=Enter, 76=Esc, 29=Space.
- Prefix timeout: in BRK, EXT or EXT_BRK with no strobe for PREFIX_TIMEOUT cycles, return to IDLE. No held change.
- Latency: strobe in cycle N -> key_held and key_press valid in cycle N+1.
- key_press = key_held_next & ~key_held. Keyboard typematic re-makes of an already held key produce no pulse.
- Auto-repeat:
  - A press pulse -> move_left the same cycle as key_press[0]; active_dir=LEFT; counter loads DAS_CYCLES-1.
  - D press behaves symmetrically for move_right.
  - Counter decrements every cycle while the active key is held.
  - At 0: pulse the active move output, reload ARR_CYCLES-1.
  - Last pressed direction wins. Pressing D while A is held switches active_dir to RIGHT and restarts DAS.
  - Release of the active key: active_dir=NONE, counter idle. A still-held opposite key does not resume.
  - Release of the non-active key: no effect.
- clear=1: key_held=0, active_dir=NONE, FSM=IDLE, no pulses that cycle. clear has priority over a coincident strobe; that byte is dropped.
- Counter width: clog2 of max(DAS_CYCLES, ARR_CYCLES, PREFIX_TIMEOUT). A shared down-counter is permitted only if both uses can never be live at once; otherwise use separate counters.
- Reset asserted mid-sequence returns to the reset values above immediately. The partial prefix is lost.

Decomposition:
- Package ps2_key_pkg holds:
  - scan code constants (SC_A, SC_D, SC_ENTER, SC_ESC, SC_SPACE, SC_BREAK, SC_EXT, SC_LEFT, SC_RIGHT, SC_BAT_OK, SC_BAT_ERR);
  - key bit indices;
  - FSM state encoding.
- One sub-module, key_autorepeat: held, press in; strobe out; DAS/ARR counter. Instantiate it once, driven by the resolved active direction, with a demux to move_left/move_right.

Test Plan:
- Send 1C then F0 1C -> key_held[0] 1 from the cycle after 1C until the cycle after the second 1C; exactly one key_press[0] pulse and one move_left.
- Hold A with DAS_CYCLES=20, ARR_CYCLES=5 for 40 cycles -> move_left at t0, t0+20, t0+25, t0+30, t0+35; nothing after F0 1C.
- Send 1C, 1C, 1C (typematic) -> key_press[0] pulses once; key_held stays 1.
- Send E0 6B, then E0 F0 6B -> key_held[0] set then cleared; 6B alone with no E0 prefix leaves key_held[0]=0.
- Press A, then D, then F0 23 -> move_right restarts DAS on D; after D release, no further move pulses although A is still held.
- Send F0 then no byte for PREFIX_TIMEOUT, then 29 -> decode_state returns to 0 at timeout; 29 is treated as a make (key_held[4]=1). Assert clear coincident with a strobe -> byte ignored, all outputs 0.
